lap_recorder: RTL and testbench
===============================

# lap_recorder

Lap/split capture stage between the time counter and the seven-segment driver of the stopwatch. Latches the live BCD time (SS.hh) into a small lap buffer on a debounced lap-button press and decides what the 4-digit display shows: live time, a briefly frozen split, or stored laps recalled one by one. All logic runs on the 50 MHz clock; timing uses the ~1 kHz display enable.

## Interface
Parameters:
- DEPTH, 4, number of lap slots; power of two, 2..8
- FREEZE_MS, 2000, clk_en ticks a captured split stays frozen on the display; 1..65535

Ports:
- clk  in  1  50 MHz system clock
- rst_n  in  1  asynchronous, active-low reset
- clk_en  in  1  one-cycle ~1 kHz enable pulse (display/debounce rate)
- counting  in  1  FSM output; stopwatch running
- clear  in  1  FSM reset_timer; synchronous clear, active-high
- lap_btn_n  in  1  debounced lap button, active-low level
- recall_btn_n  in  1  debounced recall button, active-low level
- live_d0..live_d3  in  4 each  live BCD digits (ms_tens, ms_hundreds, sec_ones, sec_tens)
- disp_d0..disp_d3  out  4 each  BCD digits to the seg7 driver
- showing_lap  out  1  display shows a non-live value
- lap_index  out  3  slot currently recalled (0 = oldest)
- lap_count  out  4  valid laps stored, 0..DEPTH
- full  out  1  lap_count == DEPTH

## Operation
- Press detection: each button registered every clk; press = previous 1, current 0. One pulse per press, independent of clk_en. Reset value of edge registers is 1 (released).
- Capture: lap press while counting=1 writes {live_d3..live_d0} at the press cycle into slot wr_ptr; wr_ptr increments mod DEPTH; lap_count increments. Lap press while counting=0 ignored entirely (no write, no state change).
- FSM states LIVE, FREEZE, RECALL:
  - LIVE: disp = live digits. Accepted capture -> FREEZE, frozen = captured value, timer = FREEZE_MS. Recall press with lap_count>0 -> RECALL, lap_index=0; with lap_count=0 ignored.
  - FREEZE: disp = frozen. Timer decrements on clk_en; on the clk_en that makes it 0 -> LIVE. Accepted capture re-freezes new value, timer reloaded. Recall press -> RECALL, lap_index=0.
  - RECALL: disp = slot (oldest + lap_index) mod DEPTH. Recall press: if lap_index == lap_count-1 -> LIVE, else lap_index+1. Accepted capture stored but state and lap_index unchanged.
- Oldest slot: 0 when not full; wr_ptr when full (wrap build only).
- Priority: clear > lap press > recall press. Simultaneous lap and recall in one cycle: recall dropped.
- clear: lap_count=0, wr_ptr=0, lap_index=0, all slots zeroed, state LIVE, timer 0; takes effect the next edge.
- showing_lap = (state != LIVE). full combinational from lap_count.

## Timing
- Reset values: state LIVE, disp_d0..d3 = 0, showing_lap 0, lap_index 0, lap_count 0, full 0, slots 0, timer 0.
- disp_* and showing_lap registered: 1 clk latency from live input change or state change.
- Button falling edge at input -> capture/state change visible on outputs 2 clk later (edge register + state/output register).
- Freeze duration: exactly FREEZE_MS clk_en pulses after the capture cycle.
- Reset asserted mid-operation: all state returns to reset values immediately, asynchronously.

## Configuration
- LAP_WRAP_EN defined: capture when full overwrites oldest slot; lap_count stays DEPTH; recall order starts at oldest surviving lap.
- LAP_WRAP_EN undefined: capture when full ignored (no write, no FREEZE, display unchanged); full stays 1 until clear.

## Test plan
- Reset then live digits 3,9,4,1 -> disp = 3,9,4,1 one clk later; showing_lap 0, lap_count 0.
- counting=1, live 12.34, lap press -> slot0 = 12.34, lap_count 1, disp frozen 12.34 for exactly 2000 clk_en, then live.
- counting=0, lap press -> no write, lap_count 0, showing_lap 0.
- Three laps (05.00, 10.00, 15.00), then 4 recall presses -> disp 05.00 (idx0), 10.00, 15.00, then live with showing_lap 0.
- Five captures with DEPTH=4: without LAP_WRAP_EN 5th ignored, full=1, recall starts at lap 1; with LAP_WRAP_EN recall starts at lap 2 and ends at lap 5.
- Lap and recall in same cycle while RECALL idx1 -> lap stored, lap_index stays 1; then clear -> lap_count 0, LIVE, disp live.

Source files
------------

// File: rtl/lap_recorder.sv
// Lap/split capture between the stopwatch time counter and the seg7 driver.
// Optional build macro LAP_WRAP_EN: when full, new laps overwrite the oldest slot.
module lap_recorder #(
    parameter int DEPTH     = 4,
    parameter int FREEZE_MS = 2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       counting,
    input  logic       clear,
    input  logic       lap_btn_n,
    input  logic       recall_btn_n,
    input  logic [3:0] live_d0,
    input  logic [3:0] live_d1,
    input  logic [3:0] live_d2,
    input  logic [3:0] live_d3,
    output logic [3:0] disp_d0,
    output logic [3:0] disp_d1,
    output logic [3:0] disp_d2,
    output logic [3:0] disp_d3,
    output logic       showing_lap,
    output logic [2:0] lap_index,
    output logic [3:0] lap_count,
    output logic       full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef LAP_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef enum logic [1:0] {LIVE, FREEZE, RECALL} state_t;

    state_t          state_q, state_d;
    logic [15:0]     timer_q, timer_d;
    logic [15:0]     frozen_q, frozen_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [3:0]      count_q, count_d;
    logic [2:0]      idx_q, idx_d;
    logic [15:0]     slots [DEPTH];
    logic [15:0]     disp_q, disp_d;
    logic            lap_q, lap_qq, rec_q, rec_qq;
    logic            lap_press, rec_press, lap_take, rec_take, cap, wr_en;
    logic [15:0]     live_word, slot_rd;
    logic [PW-1:0]   oldest_d, rd_slot;

    assign live_word = {live_d3, live_d2, live_d1, live_d0};
    assign full      = (count_q == 4'(DEPTH));
    assign lap_press = lap_qq & ~lap_q;
    assign rec_press = rec_qq & ~rec_q;
    assign lap_take  = lap_press & counting;
    assign rec_take  = rec_press & ~lap_take;
    assign cap       = lap_take & (WRAP | ~full);

    // Button edge registers: released (1) out of reset so no false press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_q  <= 1'b1;
            lap_qq <= 1'b1;
            rec_q  <= 1'b1;
            rec_qq <= 1'b1;
        end else begin
            lap_q  <= lap_btn_n;
            lap_qq <= lap_q;
            rec_q  <= recall_btn_n;
            rec_qq <= rec_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        frozen_d = frozen_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        idx_d    = idx_q;
        wr_en    = 1'b0;
        if (clear) begin
            state_d  = LIVE;
            timer_d  = '0;
            frozen_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            idx_d    = '0;
        end else begin
            if (cap) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (!full) count_d = count_q + 4'd1;
            end
            unique case (state_q)
                LIVE: begin
                    if (cap) begin
                        state_d  = FREEZE;
                        frozen_d = live_word;
                        timer_d  = 16'(FREEZE_MS);
                    end else if (rec_take && count_q != 4'd0) begin
                        state_d = RECALL;
                        idx_d   = '0;
                    end
                end
                FREEZE: begin
                    if (cap) begin
                        frozen_d = live_word;
                        timer_d  = 16'(FREEZE_MS);
                    end else if (rec_take && count_q != 4'd0) begin
                        state_d = RECALL;
                        idx_d   = '0;
                        timer_d = '0;
                    end else if (clk_en) begin
                        if (timer_q <= 16'd1) begin
                            state_d = LIVE;
                            timer_d = '0;
                        end else begin
                            timer_d = timer_q - 16'd1;
                        end
                    end
                end
                RECALL: begin
                    // A capture while browsing is stored silently; the view stays put.
                    if (!cap && rec_take) begin
                        if ({1'b0, idx_q} == count_q - 4'd1) begin
                            state_d = LIVE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
                default: state_d = LIVE;
            endcase
        end
    end

    // Display is registered from next-state values, forwarding a same-cycle write.
    always_comb begin
        oldest_d = (WRAP && count_d == 4'(DEPTH)) ? wr_ptr_d : '0;
        rd_slot  = oldest_d + idx_d[PW-1:0];
        slot_rd  = (wr_en && rd_slot == wr_ptr_q) ? live_word : slots[rd_slot];
        unique case (state_d)
            FREEZE:  disp_d = frozen_d;
            RECALL:  disp_d = slot_rd;
            default: disp_d = live_word;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LIVE;
            timer_q     <= '0;
            frozen_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            disp_q      <= '0;
            showing_lap <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            frozen_q    <= frozen_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            disp_q      <= disp_d;
            showing_lap <= (state_d != LIVE);
        end
    end

    // NOTE: the lap slots are few and must read as zero after reset or clear,
    // so they are plain flops with reset rather than an inferred RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
        end else if (wr_en) begin
            slots[wr_ptr_q] <= live_word;
        end
    end

    assign disp_d0   = disp_q[3:0];
    assign disp_d1   = disp_q[7:4];
    assign disp_d2   = disp_q[11:8];
    assign disp_d3   = disp_q[15:12];
    assign lap_index = idx_q;
    assign lap_count = count_q;

endmodule

// File: tb/tb_lap_recorder.sv
// Directed self-checking bench for lap_recorder (DEPTH=4, FREEZE_MS=2000).
module tb_lap_recorder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_en, counting, clear, lap_btn_n, recall_btn_n;
    logic [3:0] live_d0, live_d1, live_d2, live_d3;
    logic [3:0] disp_d0, disp_d1, disp_d2, disp_d3;
    logic       showing_lap, full;
    logic [2:0] lap_index;
    logic [3:0] lap_count;
    logic [15:0] disp_word;

    int n_checks = 0;
    int n_fail   = 0;

    lap_recorder #(.DEPTH(4), .FREEZE_MS(2000)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .counting(counting), .clear(clear),
        .lap_btn_n(lap_btn_n), .recall_btn_n(recall_btn_n),
        .live_d0(live_d0), .live_d1(live_d1), .live_d2(live_d2), .live_d3(live_d3),
        .disp_d0(disp_d0), .disp_d1(disp_d1), .disp_d2(disp_d2), .disp_d3(disp_d3),
        .showing_lap(showing_lap), .lap_index(lap_index), .lap_count(lap_count), .full(full)
    );

    always #10 clk = ~clk;

    assign disp_word = {disp_d3, disp_d2, disp_d1, disp_d0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_live(input logic [15:0] w);
        {live_d3, live_d2, live_d1, live_d0} = w;
    endtask

    // Hold the buttons low two clocks (edge detect + state update), then release.
    task automatic press(input logic lap, input logic rec);
        lap_btn_n    = ~lap;
        recall_btn_n = ~rec;
        step(2);
        lap_btn_n    = 1'b1;
        recall_btn_n = 1'b1;
        step(2);
    endtask

    task automatic pulse_en(input int n);
        repeat (n) begin
            clk_en = 1'b1;
            step(1);
            clk_en = 1'b0;
            step(1);
        end
    endtask

    task automatic do_clear;
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(1);
    endtask

    initial begin
        rst_n = 1'b0; clk_en = 1'b0; counting = 1'b0; clear = 1'b0;
        lap_btn_n = 1'b1; recall_btn_n = 1'b1;
        set_live(16'h1493);
        step(2);
        check("rst_disp", disp_word, 16'h0000);
        check("rst_show", showing_lap, 1'b0);
        check("rst_count", lap_count, 4'd0);
        check("rst_full", full, 1'b0);
        check("rst_idx", lap_index, 3'd0);
        rst_n = 1'b1;
        step(1);
        check("live_disp", disp_word, 16'h1493);

        // Lap while stopped is ignored.
        press(1'b1, 1'b0);
        check("stop_lap_count", lap_count, 4'd0);
        check("stop_lap_show", showing_lap, 1'b0);

        // Split capture and freeze duration.
        counting = 1'b1;
        set_live(16'h1234);
        step(1);
        press(1'b1, 1'b0);
        check("cap_count", lap_count, 4'd1);
        check("cap_show", showing_lap, 1'b1);
        check("cap_disp", disp_word, 16'h1234);
        set_live(16'h5555);
        pulse_en(1999);
        check("frz_1999_show", showing_lap, 1'b1);
        check("frz_1999_disp", disp_word, 16'h1234);
        pulse_en(1);
        check("frz_end_show", showing_lap, 1'b0);
        check("frz_end_disp", disp_word, 16'h5555);
        do_clear();
        check("clr1_count", lap_count, 4'd0);

        // Three laps then walk through them.
        set_live(16'h0500); step(1); press(1'b1, 1'b0);
        set_live(16'h1000); step(1); press(1'b1, 1'b0);
        set_live(16'h1500); step(1); press(1'b1, 1'b0);
        check("three_count", lap_count, 4'd3);
        set_live(16'h7777);
        press(1'b0, 1'b1);
        check("rc0_disp", disp_word, 16'h0500);
        check("rc0_idx", lap_index, 3'd0);
        check("rc0_show", showing_lap, 1'b1);
        press(1'b0, 1'b1);
        check("rc1_disp", disp_word, 16'h1000);
        check("rc1_idx", lap_index, 3'd1);
        press(1'b0, 1'b1);
        check("rc2_disp", disp_word, 16'h1500);
        check("rc2_idx", lap_index, 3'd2);
        press(1'b0, 1'b1);
        check("rc_end_show", showing_lap, 1'b0);
        check("rc_end_disp", disp_word, 16'h7777);

        // Five captures into four slots.
        do_clear();
        for (int i = 1; i <= 5; i++) begin
            set_live(16'(i) << 8);
            step(1);
            press(1'b1, 1'b0);
            if (i == 4) check("four_full", full, 1'b1);
        end
        check("five_count", lap_count, 4'd4);
        check("five_full", full, 1'b1);
`ifdef LAP_WRAP_EN
        check("five_disp", disp_word, 16'h0500);
`else
        check("five_disp", disp_word, 16'h0400);
`endif
        press(1'b0, 1'b1);
`ifdef LAP_WRAP_EN
        check("five_first", disp_word, 16'h0200);
`else
        check("five_first", disp_word, 16'h0100);
`endif
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        check("five_last_idx", lap_index, 3'd3);
`ifdef LAP_WRAP_EN
        check("five_last", disp_word, 16'h0500);
`else
        check("five_last", disp_word, 16'h0400);
`endif
        press(1'b0, 1'b1);
        check("five_exit_show", showing_lap, 1'b0);

        // Lap and recall together while browsing index 1.
        do_clear();
        set_live(16'h0100); step(1); press(1'b1, 1'b0);
        set_live(16'h0200); step(1); press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        check("sim_pre_idx", lap_index, 3'd1);
        set_live(16'h0300); step(1);
        press(1'b1, 1'b1);
        check("sim_count", lap_count, 4'd3);
        check("sim_idx", lap_index, 3'd1);
        check("sim_show", showing_lap, 1'b1);
        check("sim_disp", disp_word, 16'h0200);
        set_live(16'h4242);
        do_clear();
        check("clr_count", lap_count, 4'd0);
        check("clr_show", showing_lap, 1'b0);
        check("clr_disp", disp_word, 16'h4242);
        check("clr_idx", lap_index, 3'd0);
        press(1'b0, 1'b1);
        check("empty_recall", showing_lap, 1'b0);

        // Asynchronous reset mid-operation.
        press(1'b1, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("async_count", lap_count, 4'd0);
        check("async_show", showing_lap, 1'b0);
        check("async_disp", disp_word, 16'h0000);
        step(1);
        rst_n = 1'b1;
        step(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
